// File: rtl/hd63701_pkg.sv
// Shared definitions for the HD63701 context save/restore engine:
// FSM encoding, transfer mode constants and a sizing helper.
package hd63701_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_SAVE = 1'b0;
  localparam logic MODE_PULL = 1'b1;

  // Index width for a slot counter; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hd63701_slot_iter.sv
// Priority encoder over the remaining slot mask: lowest set bit when
// ascending (save), highest set bit when descending (restore).
module hd63701_slot_iter
  import hd63701_pkg::*;
#(
  parameter int NREG = 5,
  parameter int IW   = idx_bits(NREG)
) (
  input  logic [NREG-1:0] mask,
  input  logic            descending,
  output logic [IW-1:0]   idx,
  output logic            valid,
  output logic [NREG-1:0] onehot
);

  // Later loop iterations override earlier ones, so the scan order picks the winner.
  always_comb begin
    idx   = '0;
    valid = |mask;
    for (int i = 0; i < NREG; i++) begin
      if (descending) begin
        if (mask[i]) idx = IW'(i);
      end else begin
        if (mask[NREG-1-i]) idx = IW'(NREG-1-i);
      end
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_onehot
    assign onehot[gi] = valid && (idx == IW'(gi));
  end

endmodule

// File: rtl/hd63701_ctx_engine.sv
// Byte-serial register context engine: pushes a masked set of 8/16-bit
// slots onto a descending stack, or pulls them back in reverse order.
module hd63701_ctx_engine
  import hd63701_pkg::*;
#(
  parameter int              NREG      = 5,
  parameter logic [NREG-1:0] WIDE_MASK = 5'b00011,
  parameter int              AW        = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               mode,
  input  logic [NREG-1:0]    reg_mask,
  input  logic [AW-1:0]      sp_in,
  input  logic [NREG*16-1:0] regs_in,
  output logic [NREG*16-1:0] regs_out,
  output logic [NREG-1:0]    reg_we,
  output logic [AW-1:0]      sp_out,
  output logic               sp_we,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      AD,
  output logic               RW,
  output logic [7:0]         DO,
  input  logic [7:0]         DI,
  input  logic               rdy
);

  localparam int IW = idx_bits(NREG);

  state_t               state_reg;
  logic                 mode_reg;
  logic [NREG-1:0]      mask_reg;
  logic [NREG-1:0]      rem_reg;
  logic [AW-1:0]        sp_reg;
  logic                 phase_reg;
  logic [NREG*16-1:0]   regs_lat_reg;
  logic [NREG*16-1:0]   regs_out_reg;
  logic                 done_reg;
  logic                 sp_we_reg;
  logic [NREG-1:0]      reg_we_reg;

  logic [IW-1:0]        cur_idx;
  logic                 cur_valid;
  logic [NREG-1:0]      cur_onehot;
  logic [15:0]          lat_words [NREG];
  logic [15:0]          cur_word;
  logic                 cur_wide;
  logic                 byte_hi;
  logic                 last_byte;
  logic [7:0]           cur_byte;
  logic [NREG-1:0]      rem_clr;
  logic                 in_xfer;

  hd63701_slot_iter #(
    .NREG (NREG),
    .IW   (IW)
  ) u_slot_iter (
    .mask       (rem_reg),
    .descending (mode_reg),
    .idx        (cur_idx),
    .valid      (cur_valid),
    .onehot     (cur_onehot)
  );

  for (genvar gi = 0; gi < NREG; gi++) begin : g_words
    assign lat_words[gi] = regs_lat_reg[16*gi +: 16];
  end

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NREG; i++) begin
      if (cur_onehot[i]) cur_word = cur_word | lat_words[i];
    end
  end

  // phase_reg counts bytes within a slot; save goes low->high, restore high->low.
  assign cur_wide  = |(WIDE_MASK & cur_onehot);
  assign byte_hi   = (mode_reg == MODE_SAVE) ? phase_reg : (cur_wide & ~phase_reg);
  assign last_byte = ~cur_wide | phase_reg;
  assign cur_byte  = byte_hi ? cur_word[15:8] : cur_word[7:0];
  assign rem_clr   = rem_reg & ~cur_onehot;
  assign in_xfer   = (state_reg == ST_XFER);

  // Pull reads the byte above SP (pre-increment); push writes at SP (post-decrement).
  assign AD       = (in_xfer && mode_reg == MODE_PULL) ? sp_reg + AW'(1) : sp_reg;
  assign RW       = in_xfer && (mode_reg == MODE_SAVE);
  assign DO       = RW ? cur_byte : 8'h00;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign sp_we    = sp_we_reg;
  assign reg_we   = reg_we_reg;
  assign sp_out   = sp_reg;
  assign regs_out = regs_out_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= MODE_SAVE;
      mask_reg     <= '0;
      rem_reg      <= '0;
      sp_reg       <= '0;
      phase_reg    <= 1'b0;
      regs_lat_reg <= '0;
      regs_out_reg <= '0;
      done_reg     <= 1'b0;
      sp_we_reg    <= 1'b0;
      reg_we_reg   <= '0;
    end else begin
      done_reg   <= 1'b0;
      sp_we_reg  <= 1'b0;
      reg_we_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mode_reg     <= mode;
            mask_reg     <= reg_mask;
            rem_reg      <= reg_mask;
            sp_reg       <= sp_in;
            regs_lat_reg <= regs_in;
            phase_reg    <= 1'b0;
            if (|reg_mask) begin
              state_reg <= ST_XFER;
            end else begin
              state_reg  <= ST_DONE;
              done_reg   <= 1'b1;
              sp_we_reg  <= 1'b1;
              reg_we_reg <= '0;
            end
          end
        end
        ST_XFER: begin
          if (rdy && cur_valid) begin
            if (mode_reg == MODE_SAVE) begin
              sp_reg <= sp_reg - AW'(1);
            end else begin
              sp_reg <= sp_reg + AW'(1);
              for (int i = 0; i < NREG; i++) begin
                if (cur_onehot[i]) begin
                  if (byte_hi) regs_out_reg[16*i+8 +: 8] <= DI;
                  else         regs_out_reg[16*i   +: 8] <= DI;
                end
              end
            end
            if (last_byte) begin
              rem_reg   <= rem_clr;
              phase_reg <= 1'b0;
              if (rem_clr == '0) begin
                state_reg  <= ST_DONE;
                done_reg   <= 1'b1;
                sp_we_reg  <= 1'b1;
                reg_we_reg <= (mode_reg == MODE_PULL) ? mask_reg : '0;
              end
            end else begin
              phase_reg <= 1'b1;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd63701_ctx_engine.sv
// Directed bench for hd63701_ctx_engine: a reference model queues the expected
// bus beats, and a bus monitor pops and compares them as the DUT completes beats.
module tb_hd63701_ctx_engine;

  localparam logic [4:0] WIDE = 5'b00011;

  typedef struct packed {
    logic [15:0] ad;
    logic        rw;
    logic [7:0]  d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        rdy = 1'b1;
  logic [4:0]  reg_mask = '0;
  logic [15:0] sp_in = '0;
  logic [79:0] regs_in = '0;
  logic [7:0]  DI = '0;
  logic [79:0] regs_out;
  logic [4:0]  reg_we;
  logic [15:0] sp_out;
  logic [15:0] AD;
  logic        sp_we, busy, done, RW;
  logic [7:0]  DO;

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  logic [15:0] exp_sp = '0;
  logic [79:0] exp_regs_out = '0;
  logic [7:0]  mem [0:65535];

  hd63701_ctx_engine dut (
    .CLK(clk), .RST(rst), .start(start), .mode(mode), .reg_mask(reg_mask),
    .sp_in(sp_in), .regs_in(regs_in), .regs_out(regs_out), .reg_we(reg_we),
    .sp_out(sp_out), .sp_we(sp_we), .busy(busy), .done(done), .AD(AD),
    .RW(RW), .DO(DO), .DI(DI), .rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: stack order, byte order and SP wrap written out directly.
  task automatic expect_op(input logic m, input logic [4:0] mk, input logic [15:0] sp,
                           input logic [79:0] regs);
    logic [15:0] s;
    logic [15:0] w;
    s = sp;
    if (m == 1'b0) begin
      for (int i = 0; i < 5; i++) begin
        if (mk[i]) begin
          w = regs[16*i +: 16];
          exp_q.push_back('{ad: s, rw: 1'b1, d: w[7:0]});
          s = s - 16'd1;
          if (WIDE[i]) begin
            exp_q.push_back('{ad: s, rw: 1'b1, d: w[15:8]});
            s = s - 16'd1;
          end
        end
      end
    end else begin
      for (int i = 4; i >= 0; i--) begin
        if (mk[i]) begin
          if (WIDE[i]) begin
            s = s + 16'd1;
            exp_q.push_back('{ad: s, rw: 1'b0, d: 8'h00});
            exp_regs_out[16*i+8 +: 8] = mem[s];
          end
          s = s + 16'd1;
          exp_q.push_back('{ad: s, rw: 1'b0, d: 8'h00});
          exp_regs_out[16*i +: 8] = mem[s];
        end
      end
    end
    exp_sp = s;
  endtask

  // Bus monitor / memory: completed beats are scored and writes land in mem.
  always @(negedge clk) begin
    beat_t b;
    DI = mem[AD];
    if (busy && !done && rdy) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", {AD, RW, DO}, 25'h0);
      end else begin
        b = exp_q.pop_front();
        check("beat", {AD, RW, RW ? DO : 8'h00}, b);
      end
      if (RW) mem[AD] = DO;
    end
  end

  task automatic run_op(input string tag, input logic m, input logic [4:0] mk,
                        input logic [15:0] sp, input logic [79:0] regs,
                        input int stall_at, input int stall_len, input logic [15:0] stall_ad,
                        input int pulse_at, input int exp_lat);
    int c;
    expect_op(m, mk, sp, regs);
    @(posedge clk); #1;
    start = 1'b1; mode = m; reg_mask = mk; sp_in = sp; regs_in = regs; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m; reg_mask = ~mk; sp_in = ~sp; regs_in = ~regs;
    c = 1;
    while (!done && c < 64) begin
      rdy = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      start = (c == pulse_at);
      if (stall_len > 0 && c >= stall_at && c <= stall_at + stall_len)
        check({tag, "_stall_ad"}, AD, stall_ad);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    rdy = 1'b1;
    check({tag, "_latency"}, c, exp_lat);
    check({tag, "_sp_out"}, sp_out, exp_sp);
    check({tag, "_done_strobes"}, {busy, sp_we, reg_we, RW, DO, AD},
          {1'b1, 1'b1, (m ? mk : 5'b0), 1'b0, 8'h00, exp_sp});
    check({tag, "_regs_out"}, regs_out, exp_regs_out);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {busy, done, sp_we, reg_we}, 8'h00);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    $display("op %s mode=%0d mask=%05b sp_in=%04h sp_out=%04h cycles=%0d",
             tag, m, mk, sp, sp_out, c);
  endtask

  initial begin
    logic [79:0] regs_a;
    logic [79:0] regs_b;
    logic [55:0] gold;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0002] = 8'h11;
    mem[16'h0003] = 8'h22;
    regs_a = {16'h00D0, 16'h00BC, 16'h009A, 16'h5678, 16'h1234};
    regs_b = {16'hEED0, 16'h00BC, 16'h009A, 16'h5678, 16'h1234};
    gold   = 56'hD0BC9A56781234;

    #12;
    check("reset_outputs", {busy, done, sp_we, reg_we, RW, DO, AD, sp_out}, 49'h0);
    check("reset_regs_out", regs_out, 80'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("save_all", 1'b0, 5'b11111, 16'h00FF, regs_a, 0, 0, 16'h0, 0, 8);
    for (int i = 0; i < 7; i++)
      check("save_all_mem", mem[16'h00F9 + 16'(i)], gold[8*(6-i) +: 8]);

    run_op("restore_all", 1'b1, 5'b11111, 16'h00F8, regs_a, 0, 0, 16'h0, 0, 8);
    check("restore_all_values", regs_out, regs_a);

    run_op("save_stall", 1'b0, 5'b11111, 16'h00FF, regs_b, 3, 2, 16'h00FD, 0, 10);
    check("narrow_high_ignored", mem[16'h00F9], 8'hD0);

    run_op("save_wrap", 1'b0, 5'b00010, 16'h0001, {48'h0, 16'hAA55, 16'h0}, 0, 0, 16'h0, 2, 3);
    check("save_wrap_mem", {mem[16'h0001], mem[16'h0000]}, 16'h55AA);

    run_op("restore_part", 1'b1, 5'b10001, 16'h0000, regs_a, 0, 0, 16'h0, 0, 4);
    check("restore_part_values", regs_out,
          {16'h0055, 16'h00BC, 16'h009A, 16'h5678, 16'h1122});

    run_op("save_empty", 1'b0, 5'b00000, 16'h1234, regs_a, 0, 0, 16'h0, 0, 1);
    run_op("restore_empty", 1'b1, 5'b00000, 16'h4321, regs_a, 0, 0, 16'h0, 0, 1);

    // Abort a save during its fourth beat, then restore from a clean state.
    expect_op(1'b0, 5'b11111, 16'h00FF, regs_a);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; reg_mask = 5'b11111; sp_in = 16'h00FF; regs_in = regs_a;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_beat4_ad", {busy, RW, AD}, {1'b1, 1'b1, 16'h00FC});
    rst = 1'b1;
    #1;
    check("abort_outputs", {busy, done, sp_we, reg_we, RW, DO, AD, sp_out}, 49'h0);
    check("abort_regs_out", regs_out, 80'h0);
    @(posedge clk); #1;
    check("abort_held", {busy, done, sp_we, reg_we}, 8'h00);
    rst = 1'b0;
    exp_q.delete();
    exp_regs_out = '0;
    $display("op abort_save reset during beat 4");

    run_op("restore_post_rst", 1'b1, 5'b11111, 16'h00F8, regs_a, 0, 0, 16'h0, 0, 8);
    check("restore_post_rst_values", regs_out, regs_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
